// File: rtl/noc_vc_input_buffer.sv
// rtl/noc_vc_input_buffer.sv - NoC router input port: per-VC flit FIFOs, framing check, XY route, credits
module noc_vc_input_buffer #(
  parameter int MESH_SIZE_X  = 4,
  parameter int MESH_SIZE_Y  = 4,
  parameter int HEAD_PAYLOAD = 16,
  parameter int NUM_VC       = 2,
  parameter int BUF_DEPTH    = 4,
  parameter int CUR_X        = 0,
  parameter int CUR_Y        = 0,
  localparam int XW     = ($clog2(MESH_SIZE_X) < 1) ? 1 : $clog2(MESH_SIZE_X),
  localparam int YW     = ($clog2(MESH_SIZE_Y) < 1) ? 1 : $clog2(MESH_SIZE_Y),
  localparam int VCW    = ($clog2(NUM_VC) < 1) ? 1 : $clog2(NUM_VC),
  localparam int FLIT_W = 2 + XW + YW + HEAD_PAYLOAD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [VCW-1:0]             in_vc,
  input  logic [FLIT_W-1:0]          in_flit,
  output logic [NUM_VC-1:0]          out_valid,
  output logic [NUM_VC*FLIT_W-1:0]   out_flit,
  output logic [NUM_VC*3-1:0]        out_port,
  input  logic [NUM_VC-1:0]          out_ready,
  output logic [NUM_VC-1:0]          credit_out,
  output logic                       err_overflow,
  output logic                       err_protocol
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam logic [PW:0] FULL_CNT = BUF_DEPTH[PW:0];

  localparam logic [1:0] LBL_HEAD = 2'd0;
  localparam logic [1:0] LBL_BODY = 2'd1;
  localparam logic [1:0] LBL_TAIL = 2'd2;
  localparam logic [1:0] LBL_HT   = 2'd3;

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_EAST  = 3'd1;
  localparam logic [2:0] P_WEST  = 3'd2;
  localparam logic [2:0] P_NORTH = 3'd3;
  localparam logic [2:0] P_SOUTH = 3'd4;

  typedef enum logic {IN_IDLE, IN_PKT} in_state_t;

  logic [1:0]        in_label;
  logic              vc_ok;
  logic [NUM_VC-1:0] ovf_v;
  logic [NUM_VC-1:0] proto_v;

  assign in_label = in_flit[FLIT_W-1 -: 2];
  assign vc_ok    = 32'(in_vc) < NUM_VC;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [FLIT_W-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic [2:0]        route_q, route_c;
    logic              credit_q;
    in_state_t         state_q, state_d;
    logic              sel, full, lbl_ok, push, pop, is_head;
    logic [FLIT_W-1:0] head;
    logic [XW-1:0]     hx;
    logic [YW-1:0]     hy;

    assign sel  = in_valid && vc_ok && (32'(in_vc) == v);
    // Fullness is judged before this cycle's pop, so a full VC never takes a flit.
    assign full = (count == FULL_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IN_IDLE;
      else        state_q <= state_d;
    end

    always_comb begin
      state_d = state_q;
      lbl_ok  = 1'b0;
      case (state_q)
        IN_IDLE: begin
          if (in_label == LBL_HEAD) begin
            lbl_ok  = 1'b1;
            state_d = IN_PKT;
          end else if (in_label == LBL_HT) begin
            lbl_ok  = 1'b1;
          end
        end
        IN_PKT: begin
          if (in_label == LBL_BODY) begin
            lbl_ok  = 1'b1;
          end else if (in_label == LBL_TAIL) begin
            lbl_ok  = 1'b1;
            state_d = IN_IDLE;
          end
        end
      endcase
      if (!sel || full) state_d = state_q;
    end

    assign push       = sel && !full && lbl_ok;
    assign ovf_v[v]   = sel && full;
    assign proto_v[v] = sel && !full && !lbl_ok;

    assign head    = mem[rd_ptr];
    assign hx      = head[HEAD_PAYLOAD+YW +: XW];
    assign hy      = head[HEAD_PAYLOAD +: YW];
    assign is_head = (head[FLIT_W-1 -: 2] == LBL_HEAD) || (head[FLIT_W-1 -: 2] == LBL_HT);

    always_comb begin
      if (hx > XW'(CUR_X))      route_c = P_EAST;
      else if (hx < XW'(CUR_X)) route_c = P_WEST;
      else if (hy > YW'(CUR_Y)) route_c = P_NORTH;
      else if (hy < YW'(CUR_Y)) route_c = P_SOUTH;
      else                      route_c = P_LOCAL;
    end

    assign out_valid[v]              = (count != '0);
    assign pop                       = out_valid[v] && out_ready[v];
    assign out_flit[v*FLIT_W +: FLIT_W] = head;
    assign out_port[v*3 +: 3]        = (out_valid[v] && is_head) ? route_c : route_q;
    assign credit_out[v]             = credit_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        route_q  <= P_LOCAL;
        credit_q <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
          if (is_head) route_q <= route_c;
        end
        count    <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        credit_q <= pop;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_flit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      if (|ovf_v) err_overflow <= 1'b1;
      if ((|proto_v) || (in_valid && !vc_ok)) err_protocol <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// tb/tb_noc_vc_input_buffer.sv - self-checking bench for noc_vc_input_buffer (4x4 mesh, router at (1,1))
module tb_noc_vc_input_buffer;
  localparam int FW = 22;
  localparam int HP = 16;
  localparam logic [1:0] L_HEAD = 2'd0, L_BODY = 2'd1, L_TAIL = 2'd2, L_HT = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [0:0]    in_vc = '0;
  logic [FW-1:0] in_flit = '0;
  logic [1:0]    out_ready = '0;
  logic [1:0]    out_valid;
  logic [2*FW-1:0] out_flit;
  logic [5:0]    out_port;
  logic [1:0]    credit_out;
  logic          err_overflow, err_protocol;

  noc_vc_input_buffer #(
    .MESH_SIZE_X(4), .MESH_SIZE_Y(4), .HEAD_PAYLOAD(HP), .NUM_VC(2),
    .BUF_DEPTH(4), .CUR_X(1), .CUR_Y(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
    .out_valid(out_valid), .out_flit(out_flit), .out_port(out_port), .out_ready(out_ready),
    .credit_out(credit_out), .err_overflow(err_overflow), .err_protocol(err_protocol)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] l, input int x, input int y, input int p);
    return {l, 2'(x), 2'(y), 16'(p)};
  endfunction

  function automatic bit is_hdr(input logic [FW-1:0] f);
    return (f[FW-1 -: 2] == L_HEAD) || (f[FW-1 -: 2] == L_HT);
  endfunction

  // XY routing from (1,1): x first, then y
  function automatic logic [2:0] route_f(input logic [FW-1:0] f);
    int x, y;
    x = int'(f[HP+2 +: 2]);
    y = int'(f[HP +: 2]);
    if (x > 1) return 3'd1;
    if (x < 1) return 3'd2;
    if (y > 1) return 3'd3;
    if (y < 1) return 3'd4;
    return 3'd0;
  endfunction

  // Reference model: ordered list per VC, shifted on pop
  logic [FW-1:0] mbuf [2][4];
  int            mcnt [2];
  bit            minpkt [2];
  logic [2:0]    mroute [2];
  bit            movf, mproto;
  logic [1:0]    mcred;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0; minpkt[i] = 0; mroute[i] = 3'd0;
    end
    movf = 0; mproto = 0; mcred = 2'b00;
  endtask

  task automatic model_step();
    bit acc;
    int v;
    logic [1:0] l, pops;
    for (int i = 0; i < 2; i++) pops[i] = (mcnt[i] > 0) && out_ready[i];
    acc = 0;
    v = int'(in_vc);
    l = in_flit[FW-1 -: 2];
    if (in_valid) begin
      if (mcnt[v] == 4) movf = 1;
      else if (!minpkt[v]) begin
        if (l == L_HEAD || l == L_HT) begin acc = 1; minpkt[v] = (l == L_HEAD); end
        else mproto = 1;
      end else begin
        if (l == L_BODY || l == L_TAIL) begin acc = 1; minpkt[v] = (l == L_BODY); end
        else mproto = 1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (pops[i]) begin
        if (is_hdr(mbuf[i][0])) mroute[i] = route_f(mbuf[i][0]);
        for (int k = 0; k < 3; k++) mbuf[i][k] = mbuf[i][k+1];
        mcnt[i]--;
      end
    end
    if (acc) begin
      mbuf[v][mcnt[v]] = in_flit;
      mcnt[v]++;
    end
    mcred = pops;
  endtask

  task automatic check_model();
    logic [FW-1:0] h;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m_valid%0d", i), 32'(out_valid[i]), 32'(mcnt[i] > 0));
      chk($sformatf("m_credit%0d", i), 32'(credit_out[i]), 32'(mcred[i]));
      if (mcnt[i] > 0) begin
        h = mbuf[i][0];
        chk($sformatf("m_flit%0d", i), 32'(out_flit[i*FW +: FW]), 32'(h));
        chk($sformatf("m_port%0d", i), 32'(out_port[i*3 +: 3]),
            32'(is_hdr(h) ? route_f(h) : mroute[i]));
      end
    end
    chk("m_err_overflow", 32'(err_overflow), 32'(movf));
    chk("m_err_protocol", 32'(err_protocol), 32'(mproto));
  endtask

  task automatic cycle(input bit iv, input int vc, input logic [FW-1:0] f, input logic [1:0] rdy);
    in_valid  = iv;
    in_vc     = 1'(vc);
    in_flit   = f;
    out_ready = rdy;
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    bit            iv;
    int            vc;
    logic [FW-1:0] f;
    logic [1:0]    rdy;
    logic [1:0]    ev;
    logic [1:0]    ec;
    logic [2:0]    ep0;
    logic [2:0]    ep1;
  } vec_t;

  vec_t tbl [14];
  int   ncred;

  initial begin
    tbl[0]  = '{1, 0, mk(L_HT,   3, 0, 16'h0011), 2'b00, 2'b01, 2'b00, 3'd1, 3'd0};
    tbl[1]  = '{0, 0, '0,                         2'b01, 2'b00, 2'b01, 3'd0, 3'd0};
    tbl[2]  = '{1, 1, mk(L_HEAD, 1, 3, 16'h0100), 2'b00, 2'b10, 2'b00, 3'd0, 3'd3};
    tbl[3]  = '{1, 1, mk(L_BODY, 0, 0, 16'h0101), 2'b10, 2'b10, 2'b10, 3'd0, 3'd3};
    tbl[4]  = '{1, 1, mk(L_BODY, 0, 0, 16'h0102), 2'b10, 2'b10, 2'b10, 3'd0, 3'd3};
    tbl[5]  = '{1, 1, mk(L_TAIL, 0, 0, 16'h0103), 2'b10, 2'b10, 2'b10, 3'd0, 3'd3};
    tbl[6]  = '{0, 0, '0,                         2'b10, 2'b00, 2'b10, 3'd0, 3'd0};
    tbl[7]  = '{0, 0, '0,                         2'b00, 2'b00, 2'b00, 3'd0, 3'd0};
    tbl[8]  = '{1, 0, mk(L_HEAD, 0, 1, 16'h0200), 2'b00, 2'b01, 2'b00, 3'd2, 3'd0};
    tbl[9]  = '{1, 1, mk(L_HEAD, 1, 1, 16'h0300), 2'b00, 2'b11, 2'b00, 3'd2, 3'd0};
    tbl[10] = '{1, 0, mk(L_TAIL, 3, 3, 16'h0201), 2'b11, 2'b01, 2'b11, 3'd2, 3'd0};
    tbl[11] = '{1, 1, mk(L_TAIL, 3, 3, 16'h0301), 2'b11, 2'b10, 2'b01, 3'd0, 3'd0};
    tbl[12] = '{0, 0, '0,                         2'b11, 2'b00, 2'b10, 3'd0, 3'd0};
    tbl[13] = '{0, 0, '0,                         2'b00, 2'b00, 2'b00, 3'd0, 3'd0};

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_credit", 32'(credit_out), 32'd0);
    chk("rst_out_port", 32'(out_port), 32'd0);
    chk("rst_err_overflow", 32'(err_overflow), 32'd0);
    chk("rst_err_protocol", 32'(err_protocol), 32'd0);

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].iv, tbl[i].vc, tbl[i].f, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_credit", i), 32'(credit_out), 32'(tbl[i].ec));
      if (tbl[i].ev[0]) chk($sformatf("tbl%0d_port0", i), 32'(out_port[2:0]), 32'(tbl[i].ep0));
      if (tbl[i].ev[1]) chk($sformatf("tbl%0d_port1", i), 32'(out_port[5:3]), 32'(tbl[i].ep1));
    end

    // Overflow: 5 pushes into a 4-deep VC, then a push to a full VC that pops the same cycle
    for (int i = 0; i < 5; i++) cycle(1, 0, mk(L_HT, 2, 1, 16'h0400 + i), 2'b00);
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    cycle(1, 0, mk(L_HT, 2, 1, 16'h04ff), 2'b01);
    ncred = int'(credit_out[0]);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, '0, 2'b01);
      ncred += int'(credit_out[0]);
    end
    chk("ovf_credits", 32'(ncred), 32'd4);

    // Framing: BODY to idle VC, then HEAD, HEAD, TAIL
    chk("proto_clear", 32'(err_protocol), 32'd0);
    cycle(1, 1, mk(L_BODY, 0, 0, 16'h0500), 2'b00);
    chk("proto_body_idle", 32'(err_protocol), 32'd1);
    cycle(1, 1, mk(L_HEAD, 2, 1, 16'h0a0a), 2'b00);
    cycle(1, 1, mk(L_HEAD, 0, 0, 16'h0b0b), 2'b00);
    cycle(1, 1, mk(L_TAIL, 0, 0, 16'h0c0c), 2'b00);
    chk("proto_head_flit", 32'(out_flit[FW +: FW]), 32'(mk(L_HEAD, 2, 1, 16'h0a0a)));
    chk("proto_head_port", 32'(out_port[5:3]), 32'd1);
    ncred = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, '0, 2'b10);
      ncred += int'(credit_out[1]);
    end
    chk("proto_credits", 32'(ncred), 32'd2);

    // Reset mid-packet with three flits buffered
    cycle(1, 0, mk(L_HEAD, 1, 0, 16'h0600), 2'b00);
    cycle(1, 0, mk(L_BODY, 0, 0, 16'h0601), 2'b00);
    cycle(1, 0, mk(L_BODY, 0, 0, 16'h0602), 2'b00);
    chk("prerst_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    out_ready = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_err", 32'({err_overflow, err_protocol}), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_credit", 32'(credit_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_model();
    cycle(1, 0, mk(L_HEAD, 1, 2, 16'h0700), 2'b00);
    chk("post_rst_head", 32'(out_valid), 32'd1);
    chk("post_rst_port", 32'(out_port[2:0]), 32'd3);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 1)),
            mk(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom)),
            2'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/noc_vc_input_buffer.md
Name: noc_vc_input_buffer

Overview:
- Parametrised router input port for the X×Y mesh NoC.
- Buffers incoming flits in NUM_VC independent virtual-channel FIFOs and checks HEAD/BODY/TAIL/HEADTAIL packet framing per VC.
- Computes the dimension-ordered (XY) output port from each head flit and holds it for the rest of the packet.
- Returns one credit per dequeued flit to the upstream router; sits between the link and the switch allocator.

Parameters:
- MESH_SIZE_X, 4, mesh columns; XW = max(1, $clog2(MESH_SIZE_X)).
- MESH_SIZE_Y, 4, mesh rows; YW = max(1, $clog2(MESH_SIZE_Y)).
- HEAD_PAYLOAD, 16, header payload bits.
- NUM_VC, 2, virtual channels; VCW = max(1, $clog2(NUM_VC)).
- BUF_DEPTH, 4, flits per VC FIFO (power of two, ≥2).
- CUR_X, 0, this router's x coordinate.
- CUR_Y, 0, this router's y coordinate.
- Derived: FLIT_W = 2 + XW + YW + HEAD_PAYLOAD.
- Flit layout: [FLIT_W-1:FLIT_W-2] label (HEAD=0, BODY=1, TAIL=2, HEADTAIL=3), then x_dest[XW], then y_dest[YW], then payload (LSBs).
- x_dest/y_dest are only meaningful on HEAD/HEADTAIL.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  flit present on link this cycle.
- in_vc  in  VCW  target VC of in_flit.
- in_flit  in  FLIT_W  incoming flit.
- out_valid  out  NUM_VC  VC v has a flit at its FIFO head.
- out_flit  out  NUM_VC*FLIT_W  FIFO-head flit per VC, VC v at [v*FLIT_W +: FLIT_W].
- out_port  out  NUM_VC*3  route per VC (LOCAL=0, EAST=1, WEST=2, NORTH=3, SOUTH=4).
- out_ready  in  NUM_VC  switch accepts VC v's head flit.
- credit_out  out  NUM_VC  one-cycle pulse per VC, one credit each.
- err_overflow  out  1  sticky: flit arrived for a full VC.
- err_protocol  out  1  sticky: framing violation.

Behaviour:
- Reset (async assert, sync-release usage): all FIFOs empty; all VC states IN_IDLE; latched routes LOCAL. Outputs reset to: out_valid=0, credit_out=0, err_overflow=0, err_protocol=0, out_port=0. out_flit is don't-care while out_valid=0.
- Reset mid-packet discards everything; no credits are emitted for discarded flits.
- Input FSM per VC, two states:
  - IN_IDLE: HEAD → accept, go to IN_PKT. HEADTAIL → accept, stay. BODY/TAIL → drop, set err_protocol.
  - IN_PKT: BODY → accept, stay. TAIL → accept, go to IN_IDLE. HEAD/HEADTAIL → drop, set err_protocol, stay in IN_PKT.
- Fullness check:
  - Uses occupancy before this cycle's pop. A push to a full VC is dropped and sets err_overflow, even if that VC pops the same cycle.
  - A dropped flit does not advance the FSM.
  - Overflow takes precedence: if the VC is full, only err_overflow is set.
- in_vc ≥ NUM_VC: flit dropped, err_protocol set.
- Push latency: flit accepted at edge N → out_valid[v]=1 and out_flit valid after edge N (1 cycle). No bypass.
- out_valid[v] = FIFO v non-empty.
- Pop occurs when out_valid[v] && out_ready[v]. All VCs pop independently in the same cycle.
- Push and pop on a non-full VC in the same cycle: both occur; occupancy unchanged.
- Route computation (combinational from FIFO-head flit when its label is HEAD/HEADTAIL), unsigned compares, in priority order:
  - x_dest > CUR_X → EAST
  - x_dest < CUR_X → WEST
  - y_dest > CUR_Y → NORTH
  - y_dest < CUR_Y → SOUTH
  - else → LOCAL
- Route hold:
  - Popping a HEAD latches the route into the VC route register.
  - For BODY/TAIL at the FIFO head, out_port shows the latched route.
  - HEADTAIL does not need latching, but latching it is harmless.
- Credits: a pop on VC v at edge N → credit_out[v]=1 for exactly the cycle after edge N. Back-to-back pops give consecutive pulses.
- Pointers are log2(BUF_DEPTH) bits and wrap modulo BUF_DEPTH. Occupancy counter is log2(BUF_DEPTH)+1 bits, range 0..BUF_DEPTH.
- Error flags are sticky until reset.

Test Plan:
- Mesh 4×4, CUR=(1,1), VC0 receives HEADTAIL dest (3,0) → next cycle out_valid[0]=1, out_port[2:0]=EAST; pop → credit_out[0] pulses 1 cycle later.
- VC1 receives HEAD dest (1,3), BODY, BODY, TAIL, out_ready=1 → 4 flits out in order, all with out_port=NORTH; 4 credit pulses; FSM back to IN_IDLE.
- Interleave flits on VC0 (dest (0,1), WEST) and VC1 (dest (1,1), LOCAL) with both out_ready=1 → each VC keeps its own route; simultaneous credit_out=2'b11 seen.
- out_ready=0, push 5 flits to VC0 at BUF_DEPTH=4 → first 4 buffered, 5th dropped, err_overflow=1; draining yields exactly 4 flits and 4 credits.
- BODY sent to an idle VC, then HEAD followed by HEAD on the same VC → both violations dropped, err_protocol=1; the first HEAD's packet is unaffected.
- rst_n low mid-packet with 3 flits buffered → out_valid=0 immediately (async); no credits emitted; a new HEAD after release is accepted normally.
